// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data miss arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int MEM_LAT_DEF   = 4;
    localparam int BLK_WORDS_DEF = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FILL  = 2'd1,
        ARB_WRITE = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_t;

    // Fill counter spans issue phase plus memory latency without wrapping.
    function automatic int cnt_width(input int blk_words, input int mem_lat);
        return $clog2(blk_words + mem_lat);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the miss arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are level-held until the matching done pulse.
// Ports: slave = arbiter view, master = caches + memory view.
interface mem_arbiter_if #(
    parameter int IDXW = 3
);
    // cache requests
    logic            i_req;
    logic [15:0]     i_addr;
    logic            d_req;
    logic            d_wr;
    logic [15:0]     d_addr;
    logic [15:0]     d_wdata;
    // memory port
    logic [15:0]     mem_rdata;
    logic            mem_en;
    logic            mem_wr;
    logic [15:0]     mem_addr;
    logic [15:0]     mem_wdata;
    // cache returns
    logic            i_busy;
    logic            d_busy;
    logic            i_fill_we;
    logic            d_fill_we;
    logic [IDXW-1:0] fill_idx;
    logic [15:0]     fill_data;
    logic            i_done;
    logic            d_done;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output i_busy, d_busy, i_fill_we, d_fill_we, fill_idx, fill_data,
        output i_done, d_done
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  i_busy, d_busy, i_fill_we, d_fill_we, fill_idx, fill_data,
        input  i_done, d_done
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Grant selection between I and D miss requests; MEM_ARB_RR_EN selects round-robin ties.
// Latency: combinational.
// Backpressure: none; the caller only consumes the grant while idle.
// Ports: i_req_i/d_req_i requests, last_own_i last served owner, gnt_vld_o/gnt_own_o grant.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  owner_t last_own_i,
    output logic   gnt_vld_o,
    output owner_t gnt_own_o
);

    always_comb begin
        gnt_vld_o = i_req_i | d_req_i;
        gnt_own_o = OWN_D;
`ifdef MEM_ARB_RR_EN
        if (i_req_i && d_req_i) begin
            // tie goes to whoever was not served last
            gnt_own_o = (last_own_i == OWN_D) ? OWN_I : OWN_D;
        end else if (i_req_i) begin
            gnt_own_o = OWN_I;
        end
`else
        if (!d_req_i && i_req_i) begin
            gnt_own_o = OWN_I;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    // fixed priority has no use for history
    logic unused_last;
    assign unused_last = last_own_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between I-cache and D-cache miss handlers (block fill / write-through).
// Latency: fill done BLK_WORDS+MEM_LAT+1 cycles after accept, write done 2 cycles after accept.
// Backpressure: one transaction at a time; the losing/waiting requester sees busy until its done.
// Ports: clk, rst_n (async active-low), bus (mem_arbiter_if.slave). Option macro: MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT   = MEM_LAT_DEF,
    parameter int BLK_WORDS = BLK_WORDS_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int IDXW  = $clog2(BLK_WORDS);
    localparam int CNTW  = cnt_width(BLK_WORDS, MEM_LAT);
    localparam int BASEW = 16 - IDXW - 1;

    localparam logic [CNTW-1:0] BLK_C  = CNTW'(BLK_WORDS);
    localparam logic [CNTW-1:0] LAT_C  = CNTW'(MEM_LAT);
    localparam logic [CNTW-1:0] LAST_C = CNTW'(BLK_WORDS + MEM_LAT - 1);
    localparam logic [CNTW-1:0] ONE_C  = CNTW'(1);

    arb_state_t       state_q;
    logic [CNTW-1:0]  cnt_q;
    owner_t           owner_q;
    owner_t           last_q;
    logic [BASEW-1:0] base_q;

    logic   gnt_vld;
    owner_t gnt_own;

    mem_arb_pick u_pick (
        .i_req_i    (bus.i_req),
        .d_req_i    (bus.d_req),
        .last_own_i (last_q),
        .gnt_vld_o  (gnt_vld),
        .gnt_own_o  (gnt_own)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_D;
            last_q  <= OWN_D;
            base_q  <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    cnt_q <= '0;
                    if (gnt_vld) begin
                        owner_q <= gnt_own;
                        if (gnt_own == OWN_D) begin
                            base_q  <= bus.d_addr[15:IDXW+1];
                            state_q <= bus.d_wr ? ARB_WRITE : ARB_FILL;
                        end else begin
                            base_q  <= bus.i_addr[15:IDXW+1];
                            state_q <= ARB_FILL;
                        end
                    end
                end
                ARB_FILL: begin
                    if (cnt_q == LAST_C) begin
                        cnt_q   <= '0;
                        state_q <= ARB_DONE;
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                ARB_WRITE: begin
                    state_q <= ARB_DONE;
                end
                ARB_DONE: begin
                    last_q  <= owner_q;
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state/count; only the write path
    // forwards the (held-stable) D address and data directly.
    logic            mem_en;
    logic            mem_wr;
    logic [15:0]     mem_addr;
    logic [15:0]     mem_wdata;
    logic            fill_we;
    logic [IDXW-1:0] fill_idx;
    logic            done;

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_we   = 1'b0;
        fill_idx  = '0;
        done      = 1'b0;
        case (state_q)
            ARB_FILL: begin
                if (cnt_q < BLK_C) begin
                    mem_en   = 1'b1;
                    mem_addr = {base_q, cnt_q[IDXW-1:0], 1'b0};
                end
                // word issued at count n returns at count n+MEM_LAT
                if (cnt_q >= LAT_C) begin
                    fill_we  = 1'b1;
                    fill_idx = IDXW'(cnt_q - LAT_C);
                end
            end
            ARB_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = bus.d_addr;
                mem_wdata = bus.d_wdata;
            end
            ARB_DONE: begin
                done = 1'b1;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_fill_we = fill_we & (owner_q == OWN_I);
    assign bus.d_fill_we = fill_we & (owner_q == OWN_D);
    assign bus.fill_idx  = fill_idx;
    assign bus.fill_data = bus.mem_rdata;
    assign bus.i_done    = done & (owner_q == OWN_I);
    assign bus.d_done    = done & (owner_q == OWN_D);

    // busy follows the request combinationally; forced low while reset is held
    assign bus.i_busy = bus.i_req & ~bus.i_done & rst_n;
    assign bus.d_busy = bus.d_req & ~bus.d_done & rst_n;

    // the I path only ever needs the block base
    logic unused_i_lo;
    assign unused_i_lo = ^bus.i_addr[IDXW:0];

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-timeline reference model.
// Latency: n/a.
// Backpressure: bench requesters hold req until done, then drop it at the next edge.
module tb_mem_arbiter;

    localparam int LAT = 4;
    localparam int BW  = 8;

    logic clk;
    logic rst_n;

    mem_arbiter_if #(.IDXW(3)) bus ();

    mem_arbiter #(.MEM_LAT(LAT), .BLK_WORDS(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;
    int cyc   = 0;

    // memory contents and outstanding read returns
    logic [15:0] mem [0:32767];
    int          rq_cyc  [$];
    logic [15:0] rq_addr [$];

    // reference model: one transaction described by its start cycle
    bit          act      = 1'b0;
    int          s        = 0;
    bit          m_own_i  = 1'b0;
    bit          m_wr     = 1'b0;
    logic [11:0] m_base   = '0;
    bit          m_last_i = 1'b0;
    bit          m_idle   = 1'b1;
    bit          rand_en  = 1'b0;
    int          rst_cyc  = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_en"},    32'(bus.mem_en),    32'd0);
        chk({pfx, "_wr"},    32'(bus.mem_wr),    32'd0);
        chk({pfx, "_addr"},  32'(bus.mem_addr),  32'd0);
        chk({pfx, "_wd"},    32'(bus.mem_wdata), 32'd0);
        chk({pfx, "_ifw"},   32'(bus.i_fill_we), 32'd0);
        chk({pfx, "_dfw"},   32'(bus.d_fill_we), 32'd0);
        chk({pfx, "_idx"},   32'(bus.fill_idx),  32'd0);
        chk({pfx, "_idone"}, 32'(bus.i_done),    32'd0);
        chk({pfx, "_ddone"}, 32'(bus.d_done),    32'd0);
        chk({pfx, "_ibusy"}, 32'(bus.i_busy),    32'd0);
        chk({pfx, "_dbusy"}, 32'(bus.d_busy),    32'd0);
        chk({pfx, "_fdat"},  32'(bus.fill_data), 32'(bus.mem_rdata));
    endtask

    task automatic step();
        int          k;
        int          donek;
        bit          was_idle;
        bit          own_i;
        bit          just_i;
        bit          just_d;
        logic [15:0] a;
        logic [15:0] e_addr;
        logic [15:0] e_wd;
        logic [15:0] e_fd;
        logic [2:0]  e_idx;
        logic        e_en, e_wr, e_ifw, e_dfw, e_idn, e_ddn, e_ib, e_db;

        // grant decision for the coming edge, only when the arbiter sits in IDLE
        if (m_idle && rst_n && (bus.i_req || bus.d_req)) begin
`ifdef MEM_ARB_RR_EN
            if (bus.i_req && bus.d_req) own_i = ~m_last_i;
            else                        own_i = bus.i_req;
`else
            own_i = ~bus.d_req;
`endif
            act     = 1'b1;
            s       = cyc;
            m_own_i = own_i;
            m_wr    = own_i ? 1'b0 : bus.d_wr;
            m_base  = own_i ? bus.i_addr[15:4] : bus.d_addr[15:4];
        end

        @(posedge clk);
        #1;
        cyc++;
        while (rq_cyc.size() > 0 && rq_cyc[0] < cyc) begin
            void'(rq_cyc.pop_front());
            void'(rq_addr.pop_front());
        end
        if (rq_cyc.size() > 0 && rq_cyc[0] == cyc) begin
            void'(rq_cyc.pop_front());
            a = rq_addr.pop_front();
            bus.mem_rdata = mem[a[15:1]];
        end else begin
            bus.mem_rdata = 16'($urandom);
        end

        if (cyc == rst_cyc) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk_quiet("rst_now");
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            act       = 1'b0;
            m_last_i  = 1'b0;
        end

        @(negedge clk);
        if (!rst_n) act = 1'b0;
        was_idle = !act;
        k        = cyc - s;
        donek    = m_wr ? 2 : BW + LAT + 1;
        e_en = 0; e_wr = 0; e_ifw = 0; e_dfw = 0; e_idn = 0; e_ddn = 0;
        e_addr = '0; e_wd = '0; e_fd = '0; e_idx = '0;
        if (act) begin
            if (m_wr) begin
                if (k == 1) begin
                    e_en = 1; e_wr = 1; e_addr = bus.d_addr; e_wd = bus.d_wdata;
                end
                if (k == 2) e_ddn = 1;
            end else begin
                if (k >= 1 && k <= BW) begin
                    e_en   = 1;
                    e_addr = {m_base, 4'h0} + 16'(2 * (k - 1));
                end
                if (k >= LAT + 1 && k <= BW + LAT) begin
                    e_idx = 3'(k - 1 - LAT);
                    e_fd  = mem[{m_base, e_idx}];
                    if (m_own_i) e_ifw = 1; else e_dfw = 1;
                end
                if (k == BW + LAT + 1) begin
                    if (m_own_i) e_idn = 1; else e_ddn = 1;
                end
            end
        end
        e_ib = bus.i_req & ~e_idn & rst_n;
        e_db = bus.d_req & ~e_ddn & rst_n;

        chk("mem_en",  32'(bus.mem_en),    32'(e_en));
        chk("mem_wr",  32'(bus.mem_wr),    32'(e_wr));
        chk("i_fw",    32'(bus.i_fill_we), 32'(e_ifw));
        chk("d_fw",    32'(bus.d_fill_we), 32'(e_dfw));
        chk("fw_both", 32'(bus.i_fill_we & bus.d_fill_we), 32'd0);
        chk("i_done",  32'(bus.i_done),    32'(e_idn));
        chk("d_done",  32'(bus.d_done),    32'(e_ddn));
        chk("i_busy",  32'(bus.i_busy),    32'(e_ib));
        chk("d_busy",  32'(bus.d_busy),    32'(e_db));
        if (e_en) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            if (e_wr) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
        end
        if (e_ifw || e_dfw) begin
            chk("fill_idx",  32'(bus.fill_idx),  32'(e_idx));
            chk("fill_data", 32'(bus.fill_data), 32'(e_fd));
        end

        // memory side of the environment reacts to what the DUT actually drives
        if (bus.mem_en) begin
            if (bus.mem_wr) begin
                mem[bus.mem_addr[15:1]] = bus.mem_wdata;
            end else begin
                rq_cyc.push_back(cyc + LAT);
                rq_addr.push_back(bus.mem_addr);
            end
        end

        just_i = 1'b0;
        just_d = 1'b0;
        if (act && k == donek) begin
            act      = 1'b0;
            m_last_i = m_own_i;
            if (m_own_i) begin bus.i_req = 1'b0; just_i = 1'b1; end
            else         begin bus.d_req = 1'b0; just_d = 1'b1; end
        end
        m_idle = was_idle;

        if (rand_en && rst_n) begin
            if (!bus.i_req && !just_i && $urandom_range(3) == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 16'($urandom);
            end
            if (!bus.d_req && !just_d && $urandom_range(3) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_wr    = 1'($urandom_range(1));
                bus.d_addr  = 16'($urandom);
                bus.d_wdata = 16'($urandom);
            end
        end
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog got=running exp=finished");
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        rst_n         = 1'b0;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_wr      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = 16'h5A5A;
        #3;
        chk_quiet("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step();

        // I fill from an unaligned address
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h1236;
        repeat (16) step();

        // D write-through
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'b1;
        bus.d_addr  = 16'h0040;
        bus.d_wdata = 16'hBEEF;
        repeat (4) step();

        // simultaneous I and D fills
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h2000;
        bus.d_req  = 1'b1;
        bus.d_wr   = 1'b0;
        bus.d_addr = 16'h3452;
        repeat (30) step();

        // reset in the sixth cycle of a fill, then a clean fill
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h4568;
        step();
        rst_cyc = s + 6;
        repeat (8) step();
        rst_n   = 1'b1;
        rst_cyc = -1;
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h5ABC;
        repeat (16) step();

        // D request waiting behind a running I fill
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h6000;
        step();
        step();
        bus.d_req  = 1'b1;
        bus.d_wr   = 1'b0;
        bus.d_addr = 16'h7010;
        repeat (32) step();

        // random traffic, then drain
        rand_en = 1'b1;
        repeat (1500) step();
        rand_en = 1'b0;
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
